// File: rtl/sun_disc_pkg.sv
// Shared constants and types for the sun disc engine: segment table, slopes, colour type.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package sun_disc_pkg;

  // Segment boundaries on the fade_level axis
  localparam logic [7:0] RISE_START = 8'd64;
  localparam logic [7:0] TRAV_START = 8'd113;
  localparam logic [7:0] SET_START  = 8'd239;

  // Segment origins and slopes (slopes are pixels per fade step, scaled by 256)
  localparam logic [19:0] RISE_X0 = 20'd640;
  localparam logic [19:0] RISE_Y0 = 20'd310;
  localparam logic [19:0] RISE_SX = 20'd427;
  localparam logic [19:0] RISE_SY = 20'd1120;

  localparam logic [19:0] TRAV_X0 = 20'd560;
  localparam logic [19:0] TRAV_Y0 = 20'd100;
  localparam logic [19:0] TRAV_SX = 20'd819;
  localparam logic [19:0] TRAV_SY = 20'd0;

  localparam logic [19:0] SET_X0  = 20'd160;
  localparam logic [19:0] SET_Y0  = 20'd100;
  localparam logic [19:0] SET_SX  = 20'd1280;
  localparam logic [19:0] SET_SY  = 20'd3360;

  typedef logic [11:0] rgb444_t;

  typedef enum logic [1:0] {HIDDEN, RISE, TRAV, SET} seg_e;

  typedef enum logic [1:0] {ST_IDLE, ST_SEG, ST_MUL, ST_COMMIT} traj_state_e;

  function automatic seg_e seg_of(input logic [7:0] fade);
    if (fade < RISE_START)      return HIDDEN;
    else if (fade < TRAV_START) return RISE;
    else if (fade < SET_START)  return TRAV;
    else                        return SET;
  endfunction

  // Offset into the segment; every visible segment is shorter than 128 steps
  function automatic logic [6:0] seg_offset(input seg_e seg, input logic [7:0] fade);
    case (seg)
      RISE:    return 7'(fade - RISE_START);
      TRAV:    return 7'(fade - TRAV_START);
      SET:     return 7'(fade - SET_START);
      default: return 7'd0;
    endcase
  endfunction

  function automatic logic [19:0] seg_x0(input seg_e seg);
    case (seg)
      RISE:    return RISE_X0;
      TRAV:    return TRAV_X0;
      SET:     return SET_X0;
      default: return 20'd0;
    endcase
  endfunction

  function automatic logic [19:0] seg_y0(input seg_e seg);
    case (seg)
      RISE:    return RISE_Y0;
      TRAV:    return TRAV_Y0;
      SET:     return SET_Y0;
      default: return 20'd0;
    endcase
  endfunction

  function automatic logic [19:0] seg_sx(input seg_e seg);
    case (seg)
      RISE:    return RISE_SX;
      TRAV:    return TRAV_SX;
      SET:     return SET_SX;
      default: return 20'd0;
    endcase
  endfunction

  function automatic logic [19:0] seg_sy(input seg_e seg);
    case (seg)
      RISE:    return RISE_SY;
      TRAV:    return TRAV_SY;
      SET:     return SET_SY;
      default: return 20'd0;
    endcase
  endfunction

  // Only the rising segment moves the disc up the screen (y decreasing)
  function automatic logic seg_y_down(input seg_e seg);
    return (seg == RISE);
  endfunction

endpackage

// File: rtl/sun_traj_fsm.sv
// Per-frame trajectory evaluator: segment select then 7-cycle shift-add for x and y in parallel.
// Latency: commit 9 cycles after frame_start when visible, 2 cycles when hidden.
// Backpressure: none; a new frame_start while busy aborts and restarts from SEG.
module sun_traj_fsm
  import sun_disc_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_frame_start,
  input  logic [7:0] i_fade_level,
  output logic       o_busy,
  output logic       o_commit,
  output logic [9:0] o_x,
  output logic [8:0] o_y,
  output logic       o_vis
);

  traj_state_e r_state;
  traj_state_e w_next;

  logic [7:0]  r_fade;
  seg_e        r_seg;
  logic [6:0]  r_t;
  logic [19:0] r_mcand_x;
  logic [19:0] r_mcand_y;
  logic [19:0] r_acc_x;
  logic [19:0] r_acc_y;
  logic [2:0]  r_cnt;
  seg_e        w_seg;

  assign w_seg = seg_of(r_fade);

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // Next state and commit outputs; a frame_start always restarts at SEG and suppresses a pending commit
  always_comb begin
    w_next   = r_state;
    o_busy   = (r_state != ST_IDLE);
    o_commit = 1'b0;
    o_vis    = (r_seg != HIDDEN);
    o_x      = 10'd0;
    o_y      = 9'd0;
    if (i_frame_start) begin
      w_next = ST_SEG;
    end else begin
      case (r_state)
        ST_IDLE:   w_next = ST_IDLE;
        ST_SEG:    w_next = (w_seg == HIDDEN) ? ST_COMMIT : ST_MUL;
        ST_MUL:    w_next = (r_cnt == 3'd6) ? ST_COMMIT : ST_MUL;
        ST_COMMIT: begin
          w_next   = ST_IDLE;
          o_commit = 1'b1;
        end
        default:   w_next = ST_IDLE;
      endcase
    end
    if (r_seg != HIDDEN) begin
      o_x = 10'(seg_x0(r_seg) - (r_acc_x >> 8));
      if (seg_y_down(r_seg)) o_y = 9'(seg_y0(r_seg) - (r_acc_y >> 8));
      else                   o_y = 9'(seg_y0(r_seg) + (r_acc_y >> 8));
    end
  end

  // Fade capture, segment setup and LSB-first shift-add accumulation
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_fade    <= 8'd0;
      r_seg     <= HIDDEN;
      r_t       <= 7'd0;
      r_mcand_x <= 20'd0;
      r_mcand_y <= 20'd0;
      r_acc_x   <= 20'd0;
      r_acc_y   <= 20'd0;
      r_cnt     <= 3'd0;
    end else begin
      if (i_frame_start) r_fade <= i_fade_level;
      case (r_state)
        ST_SEG: begin
          r_seg     <= w_seg;
          r_t       <= seg_offset(w_seg, r_fade);
          r_mcand_x <= seg_sx(w_seg);
          r_mcand_y <= seg_sy(w_seg);
          r_acc_x   <= 20'd0;
          r_acc_y   <= 20'd0;
          r_cnt     <= 3'd0;
        end
        ST_MUL: begin
          if (r_t[0]) begin
            r_acc_x <= r_acc_x + r_mcand_x;
            r_acc_y <= r_acc_y + r_mcand_y;
          end
          r_mcand_x <= r_mcand_x << 1;
          r_mcand_y <= r_mcand_y << 1;
          r_t       <= r_t >> 1;
          r_cnt     <= r_cnt + 3'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/sun_disc_engine.sv
// Sun disc renderer: per-frame trajectory with double-buffered centre, 3-stage pixel pipeline with halo ring.
// Latency: rgb_valid/sun_rgb/sun_hit follow pix_valid by 3 cycles; centre commits between frames.
// Backpressure: none; accepts one pixel per cycle, fully pipelined.
module sun_disc_engine
  import sun_disc_pkg::*;
#(
  parameter int      RADIUS     = 24,
  parameter int      HALO_W     = 8,
  parameter rgb444_t COLOR_CORE = 12'hFF0,
  parameter rgb444_t COLOR_HALO = 12'hF80,
  parameter int      V_RES      = 480
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_frame_start,
  input  logic [7:0]  i_fade_level,
  input  logic        i_halo_en,
  input  logic        i_pix_valid,
  input  logic [9:0]  i_pixel_x,
  input  logic [8:0]  i_pixel_y,
  output logic        o_rgb_valid,
  output logic [11:0] o_sun_rgb,
  output logic        o_sun_hit,
  output logic        o_pos_busy,
  output logic [9:0]  o_sun_x,
  output logic [8:0]  o_sun_y
);

  localparam logic [23:0] CORE_R2 = 24'(RADIUS * RADIUS);
  localparam logic [23:0] HALO_R2 = 24'((RADIUS + HALO_W) * (RADIUS + HALO_W));

  logic        w_commit;
  logic [9:0]  w_new_x;
  logic [8:0]  w_new_y;
  logic        w_new_vis;

  logic [9:0]  r_sun_x;
  logic [8:0]  r_sun_y;
  logic        r_vis;

  logic               r_s1_vld;
  logic signed [11:0] r_s1_dx;
  logic signed [11:0] r_s1_dy;
  logic               r_s1_draw;
  logic               r_s1_halo;

  logic               r_s2_vld;
  logic [23:0]        r_s2_dist2;
  logic               r_s2_draw;
  logic               r_s2_halo;

  logic               r_s3_vld;
  rgb444_t            r_s3_rgb;
  logic               r_s3_hit;

  logic signed [11:0] w_dx;
  logic signed [11:0] w_dy;
  logic signed [23:0] w_dx_ext;
  logic signed [23:0] w_dy_ext;
  logic signed [23:0] w_dx_sq;
  logic signed [23:0] w_dy_sq;
  logic [23:0]        w_dist2;

  sun_traj_fsm u_traj (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_frame_start (i_frame_start),
    .i_fade_level  (i_fade_level),
    .o_busy        (o_pos_busy),
    .o_commit      (w_commit),
    .o_x           (w_new_x),
    .o_y           (w_new_y),
    .o_vis         (w_new_vis)
  );

  // Active centre only changes on a commit, so a frame's pixels see one stable position
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sun_x <= 10'd0;
      r_sun_y <= 9'd0;
      r_vis   <= 1'b0;
    end else if (w_commit) begin
      r_sun_x <= w_new_x;
      r_sun_y <= w_new_y;
      r_vis   <= w_new_vis;
    end
  end

  // Zero-extend before subtracting so a centre past the right edge yields negative dx, never a wrap
  assign w_dx = $signed({2'b00, i_pixel_x} - {2'b00, r_sun_x});
  assign w_dy = $signed({3'b000, i_pixel_y} - {3'b000, r_sun_y});

  // Stage 1: offsets from the centre captured together with the pixel
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s1_vld  <= 1'b0;
      r_s1_dx   <= 12'sd0;
      r_s1_dy   <= 12'sd0;
      r_s1_draw <= 1'b0;
      r_s1_halo <= 1'b0;
    end else begin
      r_s1_vld  <= i_pix_valid;
      r_s1_dx   <= w_dx;
      r_s1_dy   <= w_dy;
      r_s1_draw <= r_vis && (32'(r_sun_y) < V_RES);
      r_s1_halo <= i_halo_en;
    end
  end

  assign w_dx_ext = {{12{r_s1_dx[11]}}, r_s1_dx};
  assign w_dy_ext = {{12{r_s1_dy[11]}}, r_s1_dy};
  assign w_dx_sq  = w_dx_ext * w_dx_ext;
  assign w_dy_sq  = w_dy_ext * w_dy_ext;
  assign w_dist2  = w_dx_sq + w_dy_sq;

  // Stage 2: squared distance
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s2_vld   <= 1'b0;
      r_s2_dist2 <= 24'd0;
      r_s2_draw  <= 1'b0;
      r_s2_halo  <= 1'b0;
    end else begin
      r_s2_vld   <= r_s1_vld;
      r_s2_dist2 <= w_dist2;
      r_s2_draw  <= r_s1_draw;
      r_s2_halo  <= r_s1_halo;
    end
  end

  // Stage 3: colour select; outputs stay black whenever no valid pixel is presented
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s3_vld <= 1'b0;
      r_s3_rgb <= 12'h000;
      r_s3_hit <= 1'b0;
    end else begin
      r_s3_vld <= r_s2_vld;
      r_s3_rgb <= 12'h000;
      r_s3_hit <= 1'b0;
      if (r_s2_vld && r_s2_draw) begin
        if (r_s2_dist2 <= CORE_R2) begin
          r_s3_rgb <= COLOR_CORE;
          r_s3_hit <= 1'b1;
        end else if (r_s2_halo && (r_s2_dist2 <= HALO_R2)) begin
          r_s3_rgb <= COLOR_HALO;
          r_s3_hit <= 1'b1;
        end
      end
    end
  end

  assign o_rgb_valid = r_s3_vld;
  assign o_sun_rgb   = r_s3_rgb;
  assign o_sun_hit   = r_s3_hit;
  assign o_sun_x     = r_sun_x;
  assign o_sun_y     = r_sun_y;

endmodule
